// File: rtl/hex_date_entry_if.sv
// Bundles the user-facing signals of the date entry block: raw keys and
// switches in, the edited BCD date, cursor position and write pulse out.
interface hex_date_entry_if;
    logic [1:0]  key;
    logic [3:0]  switch;
    logic [23:0] digits;
    logic [2:0]  cursor;
    logic        wr_strobe;

    modport master (
        output key,
        output switch,
        input  digits,
        input  cursor,
        input  wr_strobe
    );

    modport slave (
        input  key,
        input  switch,
        output digits,
        output cursor,
        output wr_strobe
    );
endinterface

// File: rtl/hex_date_entry.sv
// Date entry front end: synchronizes and debounces two push-buttons and a
// 4-bit switch bank, then lets the user move an edit cursor across six BCD
// digits and write the switch value into the selected digit.
module hex_date_entry #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [23:0] INIT_DIGITS     = 24'h082301
) (
    input  logic             clk,
    input  logic             reset,
    hex_date_entry_if.slave  bus
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]            key_ff1_q, key_ff1_d;
    logic [1:0]            key_ff2_q, key_ff2_d;
    logic [3:0]            sw_ff1_q,  sw_ff1_d;
    logic [3:0]            sw_ff2_q,  sw_ff2_d;
    logic [1:0]            stable_q,  stable_d;
    logic [1:0][CNT_W-1:0] cnt_q,     cnt_d;
    logic [23:0]           digits_q,  digits_d;
    logic [2:0]            cursor_q,  cursor_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [1:0]            press;

    // Next-state logic: synchronizer shift, per-key debounce with press detection, then digit write and cursor advance
    always_comb begin
        key_ff1_d   = bus.key;
        key_ff2_d   = key_ff1_q;
        sw_ff1_d    = bus.switch;
        sw_ff2_d    = sw_ff1_q;
        stable_d    = stable_q;
        cnt_d       = cnt_q;
        press       = 2'b00;
        digits_d    = digits_q;
        cursor_d    = cursor_q;
        wr_strobe_d = 1'b0;

        for (int k = 0; k < 2; k++) begin
            if (key_ff2_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_MAX) begin
                stable_d[k] = key_ff2_q[k];
                cnt_d[k]    = '0;
                press[k]    = ~key_ff2_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end

        // The write uses the cursor before any same-edge advance takes effect.
        if (press[0]) begin
            digits_d[{cursor_q, 2'b00} +: 4] = (sw_ff2_q > 4'd9) ? 4'd9 : sw_ff2_q;
            wr_strobe_d = 1'b1;
        end

        if (press[1]) begin
            cursor_d = (cursor_q == 3'd5) ? 3'd0 : cursor_q + 3'd1;
        end
    end

    // State registers; reset returns keys to released and the date to its initial value
    always_ff @(posedge clk) begin
        if (reset) begin
            key_ff1_q   <= 2'b11;
            key_ff2_q   <= 2'b11;
            sw_ff1_q    <= 4'hF;
            sw_ff2_q    <= 4'hF;
            stable_q    <= 2'b11;
            cnt_q       <= '0;
            digits_q    <= INIT_DIGITS;
            cursor_q    <= 3'd0;
            wr_strobe_q <= 1'b0;
        end else begin
            key_ff1_q   <= key_ff1_d;
            key_ff2_q   <= key_ff2_d;
            sw_ff1_q    <= sw_ff1_d;
            sw_ff2_q    <= sw_ff2_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            cursor_q    <= cursor_d;
            wr_strobe_q <= wr_strobe_d;
        end
    end

    assign bus.digits    = digits_q;
    assign bus.cursor    = cursor_q;
    assign bus.wr_strobe = wr_strobe_q;

endmodule
